fht_addr_gen: RTL
=================

# fht_addr_gen

Address generator and sequencer for the in-place radix-2 FHT. It walks all log2(N) stages, issues ping-pong RAM read addresses for the three butterfly operands and the twiddle ROM address, and drives the matching write-back addresses and enables after the fixed datapath latency. It sits directly upstream of the butterfly datapath and the data/twiddle memories, and is started and monitored by the top-level FHT control.

## Interface
- A_BIT, 8, log2 of transform length N (N = 2^A_BIT), 2 ≤ A_BIT ≤ 15
- WR_LAT, 3, cycles from oRD_ADDR1/2 issue to butterfly result valid: 1 cycle RAM read + 2 cycles butterfly
- iCLK  in  1  clock; all logic on rising edge
- iRESET  in  1  synchronous, active-high reset
- iSTART  in  1  start pulse; sampled only in IDLE
- oBUSY  out  1  high from first RUN cycle through last write
- oDONE  out  1  one-cycle pulse after final write
- oRD_BANK  out  1  bank being read this stage; write bank is ~oRD_BANK
- oRD_ADDR1  out  A_BIT  X1 read address
- oRD_ADDR2  out  A_BIT  X2 read address
- oRD_ADDR0  out  A_BIT  X0 read address, issued one cycle after ADDR1/2 of the same butterfly
- oRD_EN12 / oRD_EN0  out  1 each  read strobes aligned to their addresses
- oTW_ADDR  out  A_BIT-1  twiddle ROM address, aligned with oRD_ADDR1
- oWR_EN  out  1  write strobe for both results
- oWR_ADDR0 / oWR_ADDR1  out  A_BIT each  Y0 / Y1 write addresses
- oSTAGE  out  4  current stage index s
- oRES_BANK  out  1  bank holding the final result (A_BIT mod 2), constant

## Operation
- Input data is in bank 0, already in bit-reversed order. Stage 0 reads bank 0. oRD_BANK toggles at each stage boundary.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: wait for iSTART. iSTART=1 moves to RUN with s=0 and j=0.
  - RUN: issue one butterfly per cycle for j = 0..N/2-1.
  - DRAIN: exactly WR_LAT cycles. Then go to RUN with s+1 and the bank toggled, or to DONE if s = A_BIT-1.
  - DONE: one cycle with oDONE=1, then IDLE.
- Per issued butterfly:
  - h = 2^s, k = j & (h-1), b = (j >> s)·2h.
  - ADDR1 = b+h+k.
  - ADDR2 = b+h+((h-k) & (h-1)); for k=0 this gives ADDR2 = ADDR1.
  - ADDR0 = b+k.
  - TW_ADDR = k << (A_BIT-1-s), i.e. angle index m of 2πm/N.
- Write-back: oWR_EN, oWR_ADDR0 = b+k and oWR_ADDR1 = b+h+k are the RUN-cycle values delayed WR_LAT cycles, through a shift register.
- The shift register keeps running in DRAIN, so every issued butterfly produces exactly one write.
- iSTART is ignored while oBUSY=1 or in DONE.
- All address arithmetic is unsigned, modulo N. No carries leave the block.

## Timing
- Reset (any state, including mid-transform) puts the block in IDLE on the next edge. Reset values:
  - all addresses, oTW_ADDR, oSTAGE and oRD_BANK = 0
  - all strobes = 0, oBUSY = 0, oDONE = 0
  - delay line flushed; no write occurs after reset is sampled
- oRES_BANK is constant; it does not depend on reset.
- iSTART high at edge c: the first RUN cycle is c+1, with oBUSY=1 and oRD_EN12=1. oRD_EN0 follows at c+2.
- The write for the butterfly issued at cycle t occurs at cycle t+WR_LAT.
- The first RUN cycle of stage s+1 is one cycle after the last write of stage s. This read-after-write gap guarantees that the data read was written by the previous stage.
- Busy length: A_BIT·(N/2 + WR_LAT) cycles. For N=256 that is 1048 cycles; oDONE is in the following cycle.
- oBUSY falls in the DONE cycle.
- iSTART asserted in the same cycle as DONE is ignored. A new start is accepted from the following IDLE cycle.

## Test plan
- A_BIT=4, pulse iSTART -> oBUSY high 44 cycles, a single oDONE pulse, exactly 32 oWR_EN cycles, oRES_BANK=0.
- Stage 2, j=1 -> ADDR1=5, ADDR2=7, TW_ADDR=2; one cycle later ADDR0=1; WR_ADDR0=1 and WR_ADDR1=5 three cycles after ADDR1.
- Stage 3, j=3 -> ADDR1=11, ADDR2=13, ADDR0=3, TW_ADDR=3. Stage 0, every j -> ADDR2=ADDR1 and TW_ADDR=0.
- Stage boundary: last write of stage 1 at cycle t -> stage 2 first read at t+1 with oRD_BANK toggled (1→0).
- iRESET asserted mid stage 2 -> next cycle all outputs 0 and no further oWR_EN; a subsequent iSTART restarts at stage 0 with bank 0.
- iSTART held high for the whole run -> exactly one transform, no restart until IDLE. iSTART asserted in the DONE cycle -> ignored.

Source files
------------

// File: rtl/fht_addr_gen_if.sv
// Control and memory-address bundle of the FHT address generator.
// The master side is the generator; the slave side is the FHT control and memories.
interface fht_addr_gen_if #(
    parameter int unsigned A_BIT = 8
);
    logic             start;
    logic             busy;
    logic             done;
    logic             rd_bank;
    logic [A_BIT-1:0] rd_addr1;
    logic [A_BIT-1:0] rd_addr2;
    logic [A_BIT-1:0] rd_addr0;
    logic             rd_en12;
    logic             rd_en0;
    logic [A_BIT-2:0] tw_addr;
    logic             wr_en;
    logic [A_BIT-1:0] wr_addr0;
    logic [A_BIT-1:0] wr_addr1;
    logic [3:0]       stage;
    logic             res_bank;

    modport master (
        input  start,
        output busy, done, rd_bank, rd_addr1, rd_addr2, rd_addr0, rd_en12, rd_en0,
               tw_addr, wr_en, wr_addr0, wr_addr1, stage, res_bank
    );

    modport slave (
        output start,
        input  busy, done, rd_bank, rd_addr1, rd_addr2, rd_addr0, rd_en12, rd_en0,
               tw_addr, wr_en, wr_addr0, wr_addr1, stage, res_bank
    );
endinterface

// File: rtl/fht_addr_gen.sv
// Stage/butterfly sequencer for an in-place radix-2 FHT: issues read, twiddle
// and write-back addresses for every butterfly of every stage.
module fht_addr_gen #(
    parameter int unsigned A_BIT  = 8,
    parameter int unsigned WR_LAT = 3
) (
    input  logic           clk,
    input  logic           rst,
    fht_addr_gen_if.master bus
);
    localparam int unsigned AW = A_BIT;
    localparam int unsigned JW = A_BIT - 1;
    localparam int unsigned TW = A_BIT - 1;
    localparam int unsigned SW = 4;
    localparam int unsigned DW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
    localparam logic [JW-1:0] J_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(A_BIT - 1);
    localparam logic [DW-1:0] D_LAST = DW'(WR_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
    } wb_t;

    state_t        state, state_nxt;
    logic [SW-1:0] s, s_nxt;
    logic [JW-1:0] j, j_nxt;
    logic [DW-1:0] d, d_nxt;
    wb_t           cur, cur_nxt;
    wb_t           dl [WR_LAT];
    logic [AW-1:0] a2_q, a2_nxt;
    logic [TW-1:0] tw_q, tw_nxt;
    logic          busy_q, busy_nxt;
    logic          done_q, done_nxt;
    logic [AW-1:0] jx, h, mask, k, b;
    logic [SW-1:0] tw_sh;

    // Next-state: N/2 issue cycles then WR_LAT drain cycles per stage.
    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        j_nxt     = j;
        d_nxt     = d;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    s_nxt     = '0;
                    j_nxt     = '0;
                end
            end
            RUN: begin
                if (j == J_LAST) begin
                    state_nxt = DRAIN;
                    d_nxt     = '0;
                end else begin
                    j_nxt = j + JW'(1);
                end
            end
            DRAIN: begin
                if (d == D_LAST) begin
                    j_nxt = '0;
                    if (s == S_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                        s_nxt     = s + SW'(1);
                    end
                end else begin
                    d_nxt = d + DW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Butterfly addresses for the upcoming cycle, so they register with the state.
    always_comb begin
        jx       = AW'(j_nxt);
        h        = AW'(1) << s_nxt;
        mask     = h - AW'(1);
        k        = jx & mask;
        b        = (jx >> s_nxt) << (s_nxt + SW'(1));
        tw_sh    = S_LAST - s_nxt;
        cur_nxt  = '0;
        a2_nxt   = '0;
        tw_nxt   = '0;
        busy_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);
        done_nxt = (state_nxt == DONE);
        if (state_nxt == RUN) begin
            cur_nxt.en = 1'b1;
            cur_nxt.a0 = b + k;
            cur_nxt.a1 = b + h + k;
            a2_nxt     = b + h + ((h - k) & mask);
            tw_nxt     = TW'(k << tw_sh);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            s      <= '0;
            j      <= '0;
            d      <= '0;
            cur    <= '0;
            a2_q   <= '0;
            tw_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int unsigned i = 0; i < WR_LAT; i++) dl[i] <= '0;
        end else begin
            state  <= state_nxt;
            s      <= s_nxt;
            j      <= j_nxt;
            d      <= d_nxt;
            cur    <= cur_nxt;
            a2_q   <= a2_nxt;
            tw_q   <= tw_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            // Stage 0 of the line doubles as the X0 read, one cycle after X1/X2.
            dl[0] <= cur;
            for (int unsigned i = 1; i < WR_LAT; i++) dl[i] <= dl[i-1];
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_bank  = s[0];
    assign bus.rd_addr1 = cur.a1;
    assign bus.rd_addr2 = a2_q;
    assign bus.rd_en12  = cur.en;
    assign bus.tw_addr  = tw_q;
    assign bus.rd_en0   = dl[0].en;
    assign bus.rd_addr0 = dl[0].a0;
    assign bus.wr_en    = dl[WR_LAT-1].en;
    assign bus.wr_addr0 = dl[WR_LAT-1].a0;
    assign bus.wr_addr1 = dl[WR_LAT-1].a1;
    assign bus.stage    = s;
    assign bus.res_bank = 1'(A_BIT % 2);
endmodule
